// File: rtl/vram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter_pkg
//  Description : Shared types and constants for the video RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VADR = 3'd1,
        ST_VCAP = 3'd2,
        ST_CADR = 3'd3,
        ST_CCAP = 3'd4,
        ST_CWR  = 3'd5
    } state_t;

    localparam logic [1:0] c_WIN_DEFAULT = 2'b01;
    localparam logic [7:0] c_Q_RESET     = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Shares one single-port video RAM between video fetch
//                (priority) and Z80 accesses, stretching the CPU with wait_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int         AW  = 14,
    parameter logic [1:0] WIN = c_WIN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] vaddr,
    output logic [7:0]    vdata,
    output logic          vvalid,
    output logic          vovr,
    input  logic          mreq,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   a,
    input  logic [7:0]    d,
    output logic [7:0]    q,
    output logic          wait_n,
    output logic [AW-1:0] ramA,
    output logic          ramWe,
    output logic [7:0]    ramD,
    input  logic [7:0]    ramQ
);

    state_t        r_state;
    state_t        w_next;
    logic          r_done;
    logic          r_vpend;
    logic [AW-1:0] r_vaddrHold;

    logic          w_cpuReq;
    logic          w_decide;
    logic [AW-1:0] w_ramANext;
    logic          w_ramWeNext;
    logic [7:0]    w_ramDNext;
    logic [7:0]    w_vdataNext;
    logic          w_vvalidNext;
    logic          w_vovrNext;
    logic [7:0]    w_qNext;
    logic          w_doneNext;
    logic          w_vpendNext;
    logic [AW-1:0] w_vaddrHoldNext;

    assign w_cpuReq = !mreq && (!rd || !wr) && (a[15:14] == WIN) && !r_done;
    assign wait_n   = !w_cpuReq;
    // VCAP arbitrates like IDLE so a waiting CPU access starts straight after the capture
    assign w_decide = (r_state == ST_IDLE) || (r_state == ST_VCAP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_vpend     <= 1'b0;
            r_vaddrHold <= '0;
            ramA        <= '0;
            ramWe       <= 1'b0;
            ramD        <= 8'h00;
            vdata       <= 8'h00;
            vvalid      <= 1'b0;
            vovr        <= 1'b0;
            q           <= c_Q_RESET;
        end else begin
            r_state     <= w_next;
            r_done      <= w_doneNext;
            r_vpend     <= w_vpendNext;
            r_vaddrHold <= w_vaddrHoldNext;
            ramA        <= w_ramANext;
            ramWe       <= w_ramWeNext;
            ramD        <= w_ramDNext;
            vdata       <= w_vdataNext;
            vvalid      <= w_vvalidNext;
            vovr        <= w_vovrNext;
            q           <= w_qNext;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_VCAP: begin
                if (r_vpend || vreq)       w_next = ST_VADR;
                else if (w_cpuReq && !wr)  w_next = ST_CWR;
                else if (w_cpuReq)         w_next = ST_CADR;
                else                       w_next = ST_IDLE;
            end
            ST_VADR: w_next = ST_VCAP;
            ST_CADR: w_next = ST_CCAP;
            ST_CCAP: w_next = ST_IDLE;
            ST_CWR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ramANext      = ramA;
        w_ramWeNext     = 1'b0;
        w_ramDNext      = ramD;
        w_vdataNext     = vdata;
        w_vvalidNext    = 1'b0;
        w_vovrNext      = vovr;
        w_qNext         = q;
        w_doneNext      = r_done;
        w_vpendNext     = r_vpend;
        w_vaddrHoldNext = r_vaddrHold;

        case (r_state)
            ST_VCAP: begin
                w_vdataNext  = ramQ;
                w_vvalidNext = 1'b1;
            end
            ST_CCAP: begin
                w_qNext    = ramQ;
                w_doneNext = 1'b1;
            end
            ST_CWR:  w_doneNext = 1'b1;
            default: ;
        endcase

        if (w_decide) begin
            case (w_next)
                ST_VADR: w_ramANext = r_vpend ? r_vaddrHold : vaddr;
                ST_CWR: begin
                    w_ramANext  = a[AW-1:0];
                    w_ramDNext  = d;
                    w_ramWeNext = 1'b1;
                end
                ST_CADR: w_ramANext = a[AW-1:0];
                default: ;
            endcase
            if (w_next == ST_VADR && r_vpend) w_vpendNext = 1'b0;
        end

        // A held request always wins; a second strobe while one is held is dropped
        if (vreq) begin
            if (r_vpend) begin
                w_vovrNext = 1'b1;
            end else if (!w_decide) begin
                w_vpendNext     = 1'b1;
                w_vaddrHoldNext = vaddr;
            end
        end

        if (mreq) w_doneNext = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter with a behavioural RAM,
//                vector table, corner-case sequences and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic [7:0]    vdata;
    logic          vvalid;
    logic          vovr;
    logic          mreq, rd, wr;
    logic [15:0]   a;
    logic [7:0]    d;
    logic [7:0]    q;
    logic          wait_n;
    logic [AW-1:0] ramA;
    logic          ramWe;
    logic [7:0]    ramD;
    logic [7:0]    ramQ;

    vram_arbiter #(.AW(AW), .WIN(2'b01)) dut (
        .clock(clock), .reset(reset),
        .vreq(vreq), .vaddr(vaddr), .vdata(vdata), .vvalid(vvalid), .vovr(vovr),
        .mreq(mreq), .rd(rd), .wr(wr), .a(a), .d(d), .q(q), .wait_n(wait_n),
        .ramA(ramA), .ramWe(ramWe), .ramD(ramD), .ramQ(ramQ)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pat(input int i);
        logic [13:0] ai;
        ai = 14'(i);
        if (i == 16'h0123) return 8'h5A;
        return (ai[7:0] ^ {2'b00, ai[13:8]}) + 8'h37;
    endfunction

    // Synchronous single-port RAM: read-before-write, data one edge after address
    logic [7:0] mem [0:DEPTH-1];
    bit         memLoaded = 1'b0;
    always @(posedge clock) begin
        if (!memLoaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            memLoaded <= 1'b1;
        end else begin
            if (ramWe) mem[ramA] <= ramD;
            ramQ <= mem[ramA];
        end
    end

    logic [7:0] refMem [0:DEPTH-1];
    logic [7:0] expQ;
    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int            weCount = 0;
    logic [AW-1:0] lastWeA;
    logic [7:0]    lastWeD;
    always @(negedge clock) begin
        if (ramWe) begin
            weCount++;
            lastWeA = ramA;
            lastWeD = ramD;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        int            edgeNo;
    } vjob_t;
    vjob_t vq[$];
    bit    vidCheck = 1'b0;
    always @(negedge clock) begin
        if (vidCheck && vvalid) begin
            if (vq.size() == 0) begin
                check("vid_spurious", 32'(vvalid), 32'd0);
            end else begin
                vjob_t j;
                int    lat;
                j   = vq.pop_front();
                lat = cyc - j.edgeNo;
                check("vid_data", 32'(vdata), 32'(refMem[j.addr]));
                check("vid_latency_2to4", 32'(lat >= 2 && lat <= 4), 32'd1);
            end
        end
    end

    task automatic cpuOp(input logic isWr, input logic [15:0] addr, input logic [7:0] data,
                         output int waitLow);
        @(posedge clock); #1;
        a = addr; d = data; mreq = 1'b0; rd = isWr; wr = !isWr;
        waitLow = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (wait_n) break;
            waitLow++;
        end
        if (waitLow >= 20) check("cpu_wait_timeout", 32'(waitLow), 32'd0);
        @(posedge clock); #1;
        mreq = 1'b1; rd = 1'b1; wr = 1'b1;
        if (addr[15:14] == 2'b01) begin
            if (isWr) refMem[addr[AW-1:0]] = data;
            else      expQ = refMem[addr[AW-1:0]];
        end
    endtask

    task automatic runVideo(input logic [AW-1:0] va, output int lat);
        @(posedge clock); #1;
        vreq = 1'b1; vaddr = va;
        @(posedge clock); #1;
        vreq = 1'b0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (vvalid) begin
                lat = k;
                break;
            end
            @(posedge clock);
        end
    endtask

    typedef struct {
        bit          isVid;
        bit          isWr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  expData;
        int          expWait;
        int          expWe;
    } vec_t;
    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", nFails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int wl, lat, we0, vAt, wAt, cnt, pulses;
        logic [7:0] capV;
        bit cpuDone;

        tbl[0] = '{1'b1, 1'b0, 16'h0123, 8'h00, 8'h5A, 2, 0};
        tbl[1] = '{1'b0, 1'b1, 16'h4010, 8'hA5, 8'hFF, 2, 1};
        tbl[2] = '{1'b0, 1'b0, 16'h4010, 8'h00, 8'hA5, 3, 0};
        tbl[3] = '{1'b0, 1'b0, 16'h8000, 8'h00, 8'hA5, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 16'h7FFF, 8'h3C, 8'hA5, 2, 1};
        tbl[6] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 8'h3C, 3, 0};
        tbl[7] = '{1'b0, 1'b1, 16'hC000, 8'h77, 8'h3C, 0, 0};
        tbl[8] = '{1'b1, 1'b0, 16'h3FFF, 8'h00, 8'h3C, 2, 0};
        tbl[9] = '{1'b0, 1'b0, 16'h4123, 8'h00, 8'h5A, 3, 0};

        for (int i = 0; i < DEPTH; i++) refMem[i] = pat(i);
        expQ = 8'hFF;
        reset = 1'b1; vreq = 1'b0; vaddr = '0;
        mreq = 1'b1; rd = 1'b1; wr = 1'b1; a = 16'h0000; d = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ramA",   32'(ramA),   32'd0);
        check("rst_ramWe",  32'(ramWe),  32'd0);
        check("rst_ramD",   32'(ramD),   32'd0);
        check("rst_vdata",  32'(vdata),  32'd0);
        check("rst_vvalid", 32'(vvalid), 32'd0);
        check("rst_vovr",   32'(vovr),   32'd0);
        check("rst_q",      32'(q),      32'hFF);
        check("rst_wait_n", 32'(wait_n), 32'd1);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < NV; i++) begin
            we0 = weCount;
            if (tbl[i].isVid) begin
                runVideo(tbl[i].addr[AW-1:0], lat);
                check("tbl_vid_latency", 32'(lat), 32'(tbl[i].expWait));
                check("tbl_vid_data", 32'(vdata), 32'(tbl[i].expData));
            end else begin
                cpuOp(tbl[i].isWr, tbl[i].addr, tbl[i].data, wl);
                check("tbl_cpu_waitlow", 32'(wl), 32'(tbl[i].expWait));
                check("tbl_cpu_q", 32'(q), 32'(tbl[i].expData));
                if (tbl[i].expWe == 1) begin
                    check("tbl_we_addr", 32'(lastWeA), 32'(tbl[i].addr[AW-1:0]));
                    check("tbl_we_data", 32'(lastWeD), 32'(tbl[i].data));
                end
            end
            check("tbl_we_pulses", 32'(weCount - we0), 32'(tbl[i].expWe));
        end

        // Video and CPU read arrive on the same edge: video first, CPU two edges later
        @(posedge clock); #1;
        vreq = 1'b1; vaddr = 14'h0123;
        mreq = 1'b0; rd = 1'b0; a = 16'h4010;
        cnt = 0; vAt = -1; wAt = -1;
        @(negedge clock);
        if (!wait_n) cnt++;
        @(posedge clock); #1;
        vreq = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (vvalid && vAt < 0) vAt = k;
            if (wait_n && wAt < 0) wAt = k;
            if (!wait_n) cnt++;
            if (vAt >= 0 && wAt >= 0) break;
            @(posedge clock);
        end
        check("same_edge_vid_at", 32'(vAt), 32'd2);
        check("same_edge_cpu_at", 32'(wAt), 32'd4);
        check("same_edge_waitlow", 32'(cnt), 32'd5);
        check("same_edge_q", 32'(q), 32'hA5);
        check("same_edge_vdata", 32'(vdata), 32'h5A);
        @(posedge clock); #1;
        mreq = 1'b1; rd = 1'b1;
        expQ = 8'hA5;

        // vreq held during CADR, second vreq before service is dropped
        repeat (2) @(posedge clock);
        #1;
        mreq = 1'b0; rd = 1'b0; a = 16'h4020;
        @(posedge clock); #1;
        vreq = 1'b1; vaddr = 14'h0123;
        @(posedge clock); #1;
        vaddr = 14'h2345;
        @(posedge clock); #1;
        vreq = 1'b0;
        @(negedge clock);
        check("ovr_wait_n", 32'(wait_n), 32'd1);
        check("ovr_q", 32'(q), 32'(refMem[14'h0020]));
        check("ovr_vovr", 32'(vovr), 32'd1);
        expQ = refMem[14'h0020];
        @(posedge clock); #1;
        mreq = 1'b1; rd = 1'b1;
        @(negedge clock);
        check("ovr_fetch_addr", 32'(ramA), 32'h0123);
        pulses = 0; capV = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (vvalid) begin
                pulses++;
                capV = vdata;
            end
        end
        check("ovr_vvalid_pulses", 32'(pulses), 32'd1);
        check("ovr_vdata_first", 32'(capV), 32'(refMem[14'h0123]));
        check("ovr_sticky", 32'(vovr), 32'd1);

        // Reset in the middle of a write: ramWe drops at once, nothing is retried
        we0 = weCount;
        @(posedge clock); #1;
        mreq = 1'b0; wr = 1'b0; a = 16'h4030; d = 8'h99;
        @(posedge clock); #1;
        check("midwr_we_high", 32'(ramWe), 32'd1);
        reset = 1'b1;
        #1;
        check("midwr_we_async_drop", 32'(ramWe), 32'd0);
        check("midwr_vovr_cleared", 32'(vovr), 32'd0);
        check("midwr_q_reset", 32'(q), 32'hFF);
        mreq = 1'b1; wr = 1'b1;
        expQ = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        check("midwr_no_write", 32'(weCount - we0), 32'd0);
        cpuOp(1'b0, 16'h4030, 8'h00, wl);
        check("midwr_mem_intact", 32'(q), 32'(pat(16'h0030)));

        // Randomized traffic against the reference memory
        vq.delete();
        vidCheck = 1'b1;
        cpuDone  = 1'b0;
        fork
            begin : vidGen
                while (!cpuDone) begin
                    vjob_t j;
                    @(posedge clock); #1;
                    j.addr   = AW'($urandom_range(16'h2000, 16'h3FFF));
                    j.edgeNo = cyc + 1;
                    vreq = 1'b1; vaddr = j.addr;
                    vq.push_back(j);
                    @(posedge clock); #1;
                    vreq = 1'b0;
                    repeat ($urandom_range(7, 12)) @(posedge clock);
                end
            end
            begin : cpuGen
                for (int n = 0; n < 150; n++) begin
                    int          kind;
                    logic        isWr;
                    logic [15:0] addr;
                    logic [7:0]  dat;
                    logic [1:0]  hb;
                    kind = $urandom_range(0, 9);
                    dat  = 8'($urandom);
                    if (kind < 2) begin
                        hb = 2'($urandom_range(0, 2));
                        if (hb == 2'b01) hb = 2'b11;
                        addr = {hb, 14'($urandom)};
                        isWr = 1'($urandom_range(0, 1));
                    end else begin
                        addr = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
                        isWr = (kind < 6);
                    end
                    we0 = weCount;
                    cpuOp(isWr, addr, dat, wl);
                    if (kind < 2) begin
                        check("rnd_oow_waitlow", 32'(wl), 32'd0);
                        check("rnd_oow_no_we", 32'(weCount - we0), 32'd0);
                    end else if (isWr) begin
                        check("rnd_wr_waitlow", 32'(wl >= 2 && wl <= 4), 32'd1);
                        check("rnd_wr_one_we", 32'(weCount - we0), 32'd1);
                    end else begin
                        check("rnd_rd_waitlow", 32'(wl >= 3 && wl <= 5), 32'd1);
                    end
                    check("rnd_q", 32'(q), 32'(expQ));
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                end
                cpuDone = 1'b1;
            end
        join
        for (int k = 0; k < 20 && vq.size() != 0; k++) @(posedge clock);
        check("rnd_vid_all_served", 32'(vq.size()), 32'd0);
        check("rnd_no_overrun", 32'(vovr), 32'd0);
        vidCheck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port synchronous 16 KB video RAM between the character-slot video fetch and Z80 accesses to 0x4000–0x7FFF. Video fetch has priority; CPU accesses are stretched with wait_n until served. Sits between the CPU bus/CRTC timing and the video RAM instance, replacing the second RAM port.

## Interface
Parameters:
- AW, 14, RAM address width (window size 2^AW bytes).
- WIN, 2'b01, value of a[15:14] selecting the video window.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- vreq  in  1  one-cycle video fetch strobe, at most once per 8 clocks.
- vaddr  in  AW  video fetch address; sampled with vreq.
- vdata  out  8  last fetched video byte.
- vvalid  out  1  one-cycle pulse: vdata updated.
- vovr  out  1  sticky: a vreq was lost (pending already set); cleared by reset only.
- mreq, rd, wr  in  1  Z80 strobes, active-low.
- a  in  16  CPU address.
- d  in  8  CPU write data.
- q  out  8  CPU read data, held until next CPU read completes.
- wait_n  out  1  Z80 WAIT, active-low.
- ramA  out  AW  RAM address (registered).
- ramWe  out  1  RAM write enable, active-high (registered).
- ramD  out  8  RAM write data (registered).
- ramQ  in  8  RAM read data, valid one edge after address is sampled.

## Operation
- cpuReq = !mreq && (!rd || !wr) && a[15:14]==WIN && !done.
- wait_n = !cpuReq (combinational); goes high the cycle done is set.
- done set when CPU access completes; cleared when mreq high.
- vpend set on vreq when state≠IDLE; cleared when its fetch is issued. vreq with vpend already set → vovr=1, request dropped (vpend keeps the first vaddr).
- States: IDLE, VADR, VCAP, CADR, CCAP, CWR.
- IDLE: vreq or vpend → VADR (ramA<=vaddr or stored address). Else cpuReq && !wr → CWR (ramA<=a[AW-1:0], ramD<=d, ramWe<=1). Else cpuReq && !rd → CADR (ramA<=a). Video always beats CPU on same edge.
- VADR → VCAP. VCAP: vdata<=ramQ, vvalid<=1; → VADR if vpend, else IDLE with normal priority.
- CADR → CCAP. CCAP: q<=ramQ, done<=1 → IDLE.
- CWR: ramWe<=0, done<=1 → IDLE. Exactly one write cycle per CPU write.
- rd and wr both low: treat as write.
- Access outside window: no RAM activity, wait_n high, q unchanged.

## Timing
- Reset values: ramA=0, ramWe=0, ramD=0, vdata=0, vvalid=0, vovr=0, q=8'hFF, done=0, vpend=0, state IDLE, wait_n=1 (with mreq high).
- Video latency from IDLE: vreq sampled at edge E0; vdata valid and vvalid high after E2.
- Worst-case video latency (vreq during CADR): 4 edges; fits within 8-clock slot, so vovr never sets in normal operation.
- CPU read from IDLE: request at E0, q valid and wait_n high after E2. Write: ramWe high E0–E1, wait_n high after E1.
- CPU delayed by video: up to 2 extra edges per pending fetch.
- Reset mid-access: aborts immediately, ramWe drops asynchronously; an interrupted write is not retried.
- done prevents re-execution while the Z80 holds mreq low after wait_n releases.

## Structure
- Shared package: state enum (6 states), WIN default, reset constant for q (8'hFF).
- Single module; no sub-module. RAM instantiated by parent.

## Test plan
- Reset with mreq high → all outputs at reset values, wait_n=1, ramWe=0.
- vreq vaddr=0x0123 with RAM[0x0123]=0x5A, CPU idle → vvalid pulse after E2, vdata=0x5A.
- CPU write a=0x4010 d=0xA5 then read 0x4010 → one ramWe pulse at ramA=0x010; read returns q=0xA5, wait_n low 2 cycles.
- vreq and CPU read same edge → video served first (vvalid after E2), CPU q valid after E4, wait_n low until then.
- vreq during CADR, then second vreq before service → vovr=1, only first vaddr fetched.
- CPU read of 0x8000 or 0x0000 → no RAM access, wait_n stays 1, q unchanged.
